leaf_uplink_arbiter: RTL and testbench

- Root-side scheduler that shares the single root uplink-processing path between NUM_LEAVES leaf decoder streams.
- Each leaf presents a 64-bit valid/ready stream.
- The arbiter grants one leaf at a time, round-robin, with a bounded burst length.
- Accepted beats are forwarded through a one-entry registered output stage, tagged with the source leaf index, to the root hub's message handler.

---
 rtl/leaf_uplink_arbiter.sv | 172 +++++++++++++++++
 tb/tb_leaf_uplink_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_uplink_arbiter.sv
// leaf_uplink_arbiter: round-robin, burst-limited arbiter that shares one
// root uplink path between NUM_LEAVES leaf streams. Accepted beats pass
// through a one-entry registered output stage tagged with their source leaf.
// Optional per-leaf accepted-beat counters: define LEAF_UPLINK_ARBITER_STATS_EN.
//
// Handshake: a beat moves on a rising edge when valid and ready are both
// high; valid never depends on ready, and ready may depend on valid only
// through the granted leaf and the output stage occupancy.
module leaf_uplink_arbiter #(
    parameter int NUM_LEAVES = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 4,
    localparam int SRC_W = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH*NUM_LEAVES-1:0] in_data,
    input  logic [NUM_LEAVES-1:0]            in_valid,
    output logic [NUM_LEAVES-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [SRC_W-1:0]                 out_src,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy
`ifdef LEAF_UPLINK_ARBITER_STATS_EN
    ,
    input  logic                             stat_clear,
    output logic [32*NUM_LEAVES-1:0]         stat_beats
`endif
);

    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                  state_q;
    logic [SRC_W-1:0]        rr_ptr_q;
    logic [SRC_W-1:0]        rr_ptr_d;
    logic [SRC_W-1:0]        grant_q;
    logic [CNT_W-1:0]        burst_cnt_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [SRC_W-1:0]        out_src_q;

    logic                    pick_any;
    logic                    pick_hi_any;
    logic [SRC_W-1:0]        pick_hi;
    logic [SRC_W-1:0]        pick_lo;
    logic [SRC_W-1:0]        pick_idx;
    logic                    grant_valid;
    logic [DATA_WIDTH-1:0]   grant_data;
    logic                    out_space;
    logic                    accept;
    logic                    burst_last;
    logic                    leave_grant;

    // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall.
    always_comb begin
        pick_any    = 1'b0;
        pick_hi_any = 1'b0;
        pick_hi     = '0;
        pick_lo     = '0;
        for (int i = NUM_LEAVES - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                pick_any = 1'b1;
                pick_lo  = SRC_W'(i);
                if (i >= int'(rr_ptr_q)) begin
                    pick_hi_any = 1'b1;
                    pick_hi     = SRC_W'(i);
                end
            end
        end
        pick_idx = pick_hi_any ? pick_hi : pick_lo;
    end

    // Select the granted leaf's valid and data, and steer ready back to it only.
    always_comb begin
        grant_valid = 1'b0;
        grant_data  = '0;
        in_ready    = '0;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            if (grant_q == SRC_W'(i)) begin
                grant_valid = in_valid[i];
                grant_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                in_ready[i] = (state_q == GRANT) && out_space;
            end
        end
    end

    // The output register can take a beat when empty or draining this cycle.
    assign out_space   = !out_valid_q || out_ready;
    assign accept      = (state_q == GRANT) && grant_valid && out_space;
    assign burst_last  = (burst_cnt_q == CNT_W'(MAX_BURST - 1));
    // A dropped valid ends the grant even while the output is stalled.
    assign leave_grant = (state_q == GRANT) && (!grant_valid || (accept && burst_last));
    assign rr_ptr_d    = (grant_q == SRC_W'(NUM_LEAVES - 1)) ? '0 : grant_q + 1'b1;

    // Arbitration FSM plus the registered output stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q     <= pick_idx;
                        burst_cnt_q <= '0;
                        state_q     <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        burst_cnt_q <= burst_cnt_q + 1'b1;
                    end
                    if (leave_grant) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= grant_data;
                out_src_q   <= grant_q;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q == GRANT);

`ifdef LEAF_UPLINK_ARBITER_STATS_EN
    logic [31:0] stat_q [NUM_LEAVES];

    // Per-leaf saturating accepted-beat counters; clear wins over a same-cycle accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LEAVES; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LEAVES; i++) begin
                if (stat_clear) begin
                    stat_q[i] <= '0;
                end else if (accept && (grant_q == SRC_W'(i)) && (stat_q[i] != 32'hFFFF_FFFF)) begin
                    stat_q[i] <= stat_q[i] + 32'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_LEAVES; g++) begin : g_stat
        assign stat_beats[g*32 +: 32] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_leaf_uplink_arbiter.sv
// tb_leaf_uplink_arbiter: directed scenarios plus randomized traffic, all
// checked against a transaction-level arbiter model and an output scoreboard.
module tb_leaf_uplink_arbiter;

    localparam int NL = 4;
    localparam int DW = 64;
    localparam int MB = 4;
    localparam int SW = 2;

    logic              clk;
    logic              reset;
    logic [DW*NL-1:0]  in_data;
    logic [NL-1:0]     in_valid;
    logic [NL-1:0]     in_ready;
    logic [DW-1:0]     out_data;
    logic [SW-1:0]     out_src;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    leaf_uplink_arbiter #(
        .NUM_LEAVES (NL),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    int n_vec;
    int n_err;
    int cyc;

    logic [DW-1:0] lq [NL][$];   // beats each leaf still has to send
    bit            en [NL];      // leaf willing to present valid
    bit            ordy;         // downstream ready to drive

    // transaction-level model of the arbiter
    int            m_owner;      // granted leaf, -1 when arbitrating
    int            m_ptr;        // next leaf to be considered first
    int            m_cnt;        // beats taken in the current grant
    bit            m_ov;
    logic [DW-1:0] m_od;
    int            m_os;

    logic [71:0]   exp_q [$];    // {src, data} accepted but not yet delivered

    logic [DW-1:0] data_log [$];
    int            src_log  [$];
    int            cyc_log  [$];

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_ov    = 1'b0;
        m_od    = '0;
        m_os    = 0;
        exp_q.delete();
    endtask

    task automatic clear_logs();
        data_log.delete();
        src_log.delete();
        cyc_log.delete();
    endtask

    // Advance the model by one clock with the inputs currently driven.
    task automatic model_update();
        int hit;
        int idx;
        bit acc;
        logic [DW-1:0] d;
        if (m_owner < 0) begin
            hit = -1;
            for (int k = 0; k < NL; k++) begin
                idx = (m_ptr + k) % NL;
                if (hit < 0 && in_valid[idx]) hit = idx;
            end
            if (m_ov && ordy) m_ov = 1'b0;
            if (hit >= 0) begin
                m_owner = hit;
                m_cnt   = 0;
            end
        end else begin
            acc = in_valid[m_owner] && (!m_ov || ordy);
            if (acc) begin
                d = in_data[m_owner*DW +: DW];
                m_ov = 1'b1;
                m_od = d;
                m_os = m_owner;
                m_cnt++;
                exp_q.push_back({8'(m_owner), d});
            end else if (m_ov && ordy) begin
                m_ov = 1'b0;
            end
            if (!in_valid[m_owner] || (acc && m_cnt == MB)) begin
                m_ptr   = (m_owner + 1) % NL;
                m_owner = -1;
            end
        end
    endtask

    // ---------------- driver ----------------
    // One clock: drive at negedge, compare shortly after, advance model and leaves.
    task automatic step();
        logic [NL-1:0] exp_rdy;
        logic [NL-1:0] hs;
        logic [71:0]   e;
        @(negedge clk);
        for (int i = 0; i < NL; i++) begin
            in_valid[i] = en[i] && (lq[i].size() > 0);
            in_data[i*DW +: DW] = in_valid[i] ? lq[i][0] : '0;
        end
        out_ready = ordy;
        #1;
        exp_rdy = '0;
        if (m_owner >= 0 && (!m_ov || ordy)) exp_rdy[m_owner] = 1'b1;
        check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
        check_eq("busy", 64'(busy), 64'(m_owner >= 0));
        check_eq("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov) begin
            check_eq("out_data", out_data, m_od);
            check_eq("out_src", 64'(out_src), 64'(m_os));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_beat", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_data", out_data, e[63:0]);
                check_eq("sb_src", 64'(out_src), 64'(e[71:64]));
            end
            data_log.push_back(out_data);
            src_log.push_back(int'(out_src));
            cyc_log.push_back(cyc);
        end
        hs = in_valid & in_ready;
        model_update();
        for (int i = 0; i < NL; i++) begin
            if (hs[i]) void'(lq[i].pop_front());
        end
        cyc++;
    endtask

    task automatic run_until_drained(input int budget);
        bit done;
        ordy = 1'b1;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            step();
            done = (m_owner < 0) && !m_ov && (exp_q.size() == 0);
            for (int i = 0; i < NL; i++) begin
                if (lq[i].size() > 0) done = 1'b0;
            end
        end
        if (!done) check_eq("drain_timeout", 64'(1), 64'(0));
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = '0;
        in_data  = '0;
        ordy     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < NL; i++) begin
            lq[i].delete();
            en[i] = 1'b1;
        end
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_in_ready", 64'(in_ready), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_out_data", out_data, 64'(0));
        check_eq("rst_out_src", 64'(out_src), 64'(0));
        model_reset();
        clear_logs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        int offs [6];
        logic [DW-1:0] v;
        offs  = '{2, 3, 4, 5, 7, 8};
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        reset = 1'b0;
        in_valid = '0;
        in_data  = '0;
        out_ready = 1'b1;
        ordy = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);

        // Single leaf: six beats from leaf 2, gap after the fourth.
        reset_dut();
        for (int j = 0; j < 6; j++) lq[2].push_back(64'hA0 + 64'(j));
        t0 = cyc;
        run_until_drained(40);
        check_eq("t1_count", 64'(data_log.size()), 64'(6));
        for (int j = 0; j < 6 && j < data_log.size(); j++) begin
            check_eq("t1_data", data_log[j], 64'hA0 + 64'(j));
            check_eq("t1_src", 64'(src_log[j]), 64'(2));
            check_eq("t1_cycle", 64'(cyc_log[j] - t0), 64'(offs[j]));
        end

        // Round-robin: every leaf has 8 beats waiting.
        reset_dut();
        for (int i = 0; i < NL; i++) begin
            for (int j = 0; j < 8; j++) lq[i].push_back({32'(i), 32'(j)});
        end
        run_until_drained(200);
        check_eq("t2_count", 64'(src_log.size()), 64'(32));
        for (int j = 0; j < 32 && j < src_log.size(); j++) begin
            check_eq("t2_order", 64'(src_log[j]), 64'((j / MB) % NL));
        end

        // Backpressure: downstream stalls for 5 cycles after the first accept.
        reset_dut();
        lq[1].push_back(64'h11);
        lq[1].push_back(64'h12);
        lq[1].push_back(64'h13);
        for (int n = 0; n < 20 && lq[1].size() == 3; n++) step();
        check_eq("t3_first_accept", 64'(lq[1].size()), 64'(2));
        ordy = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            check_eq("t3_hold_data", out_data, 64'h11);
            check_eq("t3_hold_rdy", 64'(in_ready[1]), 64'(0));
        end
        run_until_drained(40);
        check_eq("t3_count", 64'(data_log.size()), 64'(3));
        for (int j = 0; j < 3 && j < data_log.size(); j++) begin
            check_eq("t3_data", data_log[j], 64'h11 + 64'(j));
        end

        // Early release: leaf 3 stops after two beats while leaf 0 waits.
        reset_dut();
        lq[3].push_back(64'h30);
        lq[3].push_back(64'h31);
        step();
        lq[0].push_back(64'h00);
        lq[0].push_back(64'h01);
        run_until_drained(40);
        check_eq("t4_count", 64'(src_log.size()), 64'(4));
        if (src_log.size() == 4) begin
            check_eq("t4_src0", 64'(src_log[0]), 64'(3));
            check_eq("t4_src1", 64'(src_log[1]), 64'(3));
            check_eq("t4_src2", 64'(src_log[2]), 64'(0));
            check_eq("t4_gap", 64'(cyc_log[2] - cyc_log[0]), 64'(4));
        end

        // Reset asserted mid-cycle with a beat in the output register.
        reset_dut();
        for (int j = 0; j < 10; j++) lq[1].push_back(64'h100 + 64'(j));
        repeat (4) step();
        @(posedge clk);
        #2;
        check_eq("t5_pre_out_valid", 64'(out_valid), 64'(1));
        reset = 1'b0;
        #1;
        check_eq("t5_out_valid", 64'(out_valid), 64'(0));
        check_eq("t5_in_ready", 64'(in_ready), 64'(0));
        check_eq("t5_busy", 64'(busy), 64'(0));
        model_reset();
        clear_logs();
        for (int i = 0; i < NL; i++) lq[i].delete();
        in_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        lq[2].push_back(64'h200);
        lq[0].push_back(64'h000);
        run_until_drained(40);
        check_eq("t5_count", 64'(src_log.size()), 64'(2));
        if (src_log.size() > 0) check_eq("t5_restart_src", 64'(src_log[0]), 64'(0));

        // Randomized traffic with random releases and backpressure.
        reset_dut();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NL; i++) begin
                if (lq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    for (int j = 0; j < $urandom_range(1, 7); j++) begin
                        v = {$urandom, $urandom};
                        lq[i].push_back(v);
                    end
                end
                if ($urandom_range(0, 19) == 0) en[i] = ~en[i];
            end
            ordy = ($urandom_range(0, 3) != 0);
            step();
        end
        for (int i = 0; i < NL; i++) en[i] = 1'b1;
        run_until_drained(500);
        check_eq("rand_sb_empty", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
